// File: rtl/rnn_pkg.sv
// Shared definitions for the RNN memory responder: bank selects, depths and FSM states.
// Optional checker logic is enabled with the RNN_RESP_CHECK_EN macro in the top.
package rnn_pkg;

  localparam int unsigned DW         = 20;
  localparam int unsigned XW         = 32;
  localparam int unsigned H          = 64;
  localparam int unsigned TW         = 11;
  localparam int unsigned CW         = 17;
  localparam int unsigned AW         = 17;
  localparam int unsigned LDAW       = 12;
  localparam int unsigned WIH_DEPTH  = 2048;
  localparam int unsigned BIH_DEPTH  = 64;
  localparam int unsigned WHH_DEPTH  = 4096;
  localparam int unsigned BHH_DEPTH  = 64;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned HSH        = $clog2(H);

  localparam logic [2:0] MSEL_WIH = 3'b000;
  localparam logic [2:0] MSEL_BIH = 3'b001;
  localparam logic [2:0] MSEL_WHH = 3'b010;
  localparam logic [2:0] MSEL_BHH = 3'b011;
  localparam logic [2:0] MSEL_T   = 3'b100;
  localparam logic [2:0] MSEL_H   = 3'b101;
  localparam logic [2:0] LD_X     = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Expected number of h(t) writes for a job of T timesteps (T*H).
  function automatic logic [CW-1:0] job_len(input logic [TW-1:0] t);
    return {t, {HSH{1'b0}}};
  endfunction

endpackage

// File: rtl/rnn_in_fifo.sv
// Small input-vector FIFO; head word is visible combinationally, 0 when empty.
module rnn_in_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // A push into a full FIFO is refused even if a pop frees a slot that cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rnn_mem_responder.sv
// Memory/handshake responder for an RNN accelerator: weight banks, x(t) FIFO, h(t) stream.
// Define RNN_RESP_CHECK_EN to build the sticky protocol checker driving err.
module rnn_mem_responder
  import rnn_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            busy,
  output logic            ready,
  input  logic            i_en,
  output logic [XW-1:0]   idata,
  input  logic            mce,
  input  logic [2:0]      msel,
  input  logic [AW-1:0]   maddr,
  input  logic [DW-1:0]   mdata_w,
  output logic [DW-1:0]   mdata_r,
  input  logic            ld_valid,
  input  logic [2:0]      ld_sel,
  input  logic [LDAW-1:0] ld_addr,
  input  logic [XW-1:0]   ld_data,
  output logic            ld_ready,
  input  logic            ld_start,
  output logic            wr_valid,
  output logic [AW-1:0]   wr_addr,
  output logic [DW-1:0]   wr_data,
  output logic            done,
  output logic [3:0]      err
);

  logic [DW-1:0] wih_mem [WIH_DEPTH];
  logic [DW-1:0] bih_mem [BIH_DEPTH];
  logic [DW-1:0] whh_mem [WHH_DEPTH];
  logic [DW-1:0] bhh_mem [BHH_DEPTH];

  logic [TW-1:0] t_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_valid_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;

  logic          ld_beat, h_wr, job_done;
  logic          fifo_full, fifo_empty;

  assign ld_beat  = ld_valid && ld_ready;
  assign h_wr     = mce && (msel == MSEL_H);
  assign job_done = (cnt_q >= job_len(t_q));

  rnn_in_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(XW)
  ) u_in_fifo (
    .clk_i  (clk),
    .rst_ni (reset),
    .push_i (ld_beat && (ld_sel == LD_X)),
    .wdata_i(ld_data),
    .pop_i  (i_en),
    .rdata_o(idata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (ld_beat) begin
      case (ld_sel)
        MSEL_WIH: wih_mem[ld_addr[10:0]] <= ld_data[DW-1:0];
        MSEL_BIH: bih_mem[ld_addr[5:0]]  <= ld_data[DW-1:0];
        MSEL_WHH: whh_mem[ld_addr[11:0]] <= ld_data[DW-1:0];
        MSEL_BHH: bhh_mem[ld_addr[5:0]]  <= ld_data[DW-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    mdata_r = '0;
    case (msel)
      MSEL_WIH: mdata_r = wih_mem[maddr[10:0]];
      MSEL_BIH: mdata_r = bih_mem[maddr[5:0]];
      MSEL_WHH: mdata_r = whh_mem[maddr[11:0]];
      MSEL_BHH: mdata_r = bhh_mem[maddr[5:0]];
      MSEL_T:   mdata_r = {{(DW-TW){1'b0}}, t_q};
      default:  mdata_r = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (ld_start) begin
        state_d = ST_ARM;
        cnt_d   = '0;
      end
      ST_ARM:  if (busy) state_d = ST_RUN;
      ST_RUN: begin
        // Saturate so runaway writes cannot wrap back below the job length.
        if (h_wr && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        if (job_done) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_ready = 1'b0;
    case (state_q)
      ST_IDLE:        ld_ready = 1'b1;
      ST_ARM, ST_RUN: ld_ready = (ld_sel == LD_X) && !fifo_full;
      default:        ld_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      t_q        <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_valid_q <= h_wr;
      if (ld_beat && (ld_sel == MSEL_T)) t_q <= ld_data[TW-1:0];
      if (h_wr) begin
        wr_addr_q <= maddr;
        wr_data_q <= mdata_w;
      end
    end
  end

  assign ready    = (state_q == ST_ARM) && !fifo_empty;
  assign done     = (state_q == ST_DONE);
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

`ifdef RNN_RESP_CHECK_EN
  logic [3:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (i_en && fifo_empty)                           err_d[0] = 1'b1;
    if ((state_q == ST_RUN) && !busy && !job_done)    err_d[1] = 1'b1;
    if (h_wr && (state_q != ST_RUN))                  err_d[2] = 1'b1;
    if ((state_q == ST_RUN) && h_wr && job_done)      err_d[3] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = '0;
`endif

endmodule

// File: tb/tb_rnn_mem_responder.sv
// Directed bench: h(t) stream checked by a queue scoreboard, other outputs by direct checks.
module tb_rnn_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        busy = 1'b0;
  logic        ready;
  logic        i_en = 1'b0;
  logic [31:0] idata;
  logic        mce = 1'b0;
  logic [2:0]  msel = 3'b000;
  logic [16:0] maddr = '0;
  logic [19:0] mdata_w = '0;
  logic [19:0] mdata_r;
  logic        ld_valid = 1'b0;
  logic [2:0]  ld_sel = 3'b000;
  logic [11:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ld_ready;
  logic        ld_start = 1'b0;
  logic        wr_valid;
  logic [16:0] wr_addr;
  logic [19:0] wr_data;
  logic        done;
  logic [3:0]  err;

`ifdef RNN_RESP_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int beats  = 0;
  logic [36:0] exp_q [$];

  rnn_mem_responder dut (
    .clk(clk), .reset(reset), .busy(busy), .ready(ready), .i_en(i_en), .idata(idata),
    .mce(mce), .msel(msel), .maddr(maddr), .mdata_w(mdata_w), .mdata_r(mdata_r),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_start(ld_start), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every wr_valid beat must match the oldest queued write.
  always @(negedge clk) begin
    if (reset && wr_valid) begin
      logic [36:0] e;
      beats++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {15'b0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {15'b0, wr_addr}, {15'b0, e[36:20]});
        check("wr_data", {12'b0, wr_data}, {12'b0, e[19:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] sel, input logic [11:0] addr, input logic [31:0] data);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_addr  = addr;
    ld_data  = data;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic hwrite(input logic [16:0] a, input logic [19:0] d);
    mce     = 1'b1;
    msel    = 3'b101;
    maddr   = a;
    mdata_w = d;
    exp_q.push_back({a, d});
    tick();
    mce = 1'b0;
  endtask

  task automatic rd(input string name, input logic [2:0] s, input logic [16:0] a,
                    input logic [19:0] exp);
    msel  = s;
    maddr = a;
    #1;
    check(name, {12'b0, mdata_r}, {12'b0, exp});
  endtask

  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done) n++;
    end
    check(name, n, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fw [4];
    fw[0] = 32'hA000_0000; fw[1] = 32'hA111_1111; fw[2] = 32'hA222_2222; fw[3] = 32'hA333_3333;

    repeat (3) tick();
    check("rst_ready",    ready, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_done",     done, 0);
    check("rst_err",      err, 0);
    check("rst_wr_addr",  wr_addr, 0);
    check("rst_wr_data",  wr_data, 0);
    check("rst_idata",    idata, 0);
    check("rst_ld_ready", ld_ready, 1);
    reset = 1'b1;
    tick();

    // Bank preload and same-cycle readback, including address aliasing on short banks.
    preload(3'b010, 12'h123, 32'h0000_ABCD);
    preload(3'b000, 12'h005, 32'hFFF1_2345);
    preload(3'b001, 12'h03F, 32'h000F_FFFF);
    preload(3'b011, 12'h001, 32'h0000_0042);
    preload(3'b100, 12'h000, 32'h0000_0002);
    rd("rd_whh", 3'b010, 17'h00123, 20'h0ABCD);
    rd("rd_wih", 3'b000, 17'h00005, 20'h12345);
    rd("rd_bih_alias", 3'b001, 17'h1FFFF, 20'hFFFFF);
    rd("rd_bhh", 3'b011, 17'h00001, 20'h00042);
    rd("rd_t", 3'b100, 17'h00000, 20'h00002);
    rd("rd_sel5", 3'b101, 17'h00123, 20'h0);
    rd("rd_sel7", 3'b111, 17'h00123, 20'h0);

    // Start handshake.
    preload(3'b110, 12'h000, 32'hDEAD_BEEF);
    check("idle_idata", idata, 32'hDEAD_BEEF);
    check("idle_ready", ready, 0);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("arm_ready", ready, 1);
    ld_sel = 3'b000; #1;
    check("arm_ld_ready_bank", ld_ready, 0);
    busy = 1'b1;
    tick();
    check("run_ready", ready, 0);
    i_en = 1'b1; #1;
    check("pop_idata", idata, 32'hDEAD_BEEF);
    tick();
    i_en = 1'b0;
    check("popped_idata", idata, 0);

    // Result stream of T*64 = 128 writes.
    for (int n = 0; n < 128; n++) hwrite(17'(n), 20'(n));
    wait_done("done_pulse_128", 8);
    ld_sel = 3'b000; #1;
    check("after_done_idle", ld_ready, 1);
    check("after_done_err", err, 0);
    busy = 1'b0;

    // Reset in the middle of a job.
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    busy = 1'b1; tick();
    for (int n = 0; n < 40; n++) hwrite(17'(1000 + n), 20'(n * 3));
    check("pre_rst_wr_valid", wr_valid, 1);
    reset = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("mid_rst_wr_valid", wr_valid, 0);
    check("mid_rst_ready", ready, 0);
    check("mid_rst_wr_addr", wr_addr, 0);
    busy = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    ld_sel = 3'b000; #1;
    check("post_rst_idle", ld_ready, 1);
    rd("post_rst_t", 3'b100, 17'h0, 20'h0);

    // T=0 after reset: zero-write job finishes on first RUN cycle.
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    busy = 1'b1; tick();
    wait_done("done_pulse_t0", 5);
    busy = 1'b0;
    check("t0_err", err, 0);

    // FIFO full / simultaneous push+pop edges, in ARM.
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int k = 0; k < 4; k++) preload(3'b110, 12'h000, fw[k]);
    ld_valid = 1'b1; ld_sel = 3'b110; ld_data = 32'h0BAD_0BAD; #1;
    check("full_ld_ready", ld_ready, 0);
    check("full_ready", ready, 1);
    i_en = 1'b1; #1;
    check("full_head", idata, fw[0]);
    tick();
    ld_valid = 1'b0; i_en = 1'b0; #1;
    check("cnt3_ld_ready", ld_ready, 1);
    for (int k = 1; k < 4; k++) begin
      check("drain_head", idata, fw[k]);
      i_en = 1'b1; tick(); i_en = 1'b0;
    end
    check("drained_idata", idata, 0);
    check("drained_ready", ready, 0);
    preload(3'b110, 12'h000, 32'hB000_0000);
    ld_valid = 1'b1; ld_sel = 3'b110; ld_data = 32'hB111_1111; i_en = 1'b1;
    tick();
    ld_valid = 1'b0; i_en = 1'b0;
    check("pushpop_head", idata, 32'hB111_1111);
    check("pushpop_ready", ready, 1);
    i_en = 1'b1; tick(); i_en = 1'b0;
    check("pushpop_empty", idata, 0);
    busy = 1'b1; tick();
    wait_done("done_pulse_fifo", 5);
    busy = 1'b0;
    check("fifo_err", err, 0);

    // Underflow and write outside RUN.
    i_en = 1'b1; #1;
    check("uflow_idata", idata, 0);
    tick();
    i_en = 1'b0;
    check("uflow_err", err, CHK_EN ? 32'h1 : 32'h0);
    tick(); tick();
    check("uflow_sticky", err, CHK_EN ? 32'h1 : 32'h0);
    hwrite(17'h1ABCD, 20'h5A5A5);
    tick();
    check("idle_write_err", err, CHK_EN ? 32'h5 : 32'h0);

    tick();
    check("sb_empty", exp_q.size(), 0);
    check("beat_count", beats, 168);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rnn_mem_responder.md
RNN_MEM_RESPONDER -- requirements
Module: rnn_mem_responder

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port busy, input, 1 bit: accelerator is running.
REQ-004 SHALL have port ready, output, 1 bit: a job is armed, asserted toward the accelerator.
REQ-005 SHALL have port i_en, input, 1 bit: one-cycle request to pop the next input word.
REQ-006 SHALL have port idata, output, 32 bits: input bit-vector x(t) at the FIFO head.
REQ-007 SHALL have ports mce (input, 1 bit), msel (input, 3 bits), maddr (input, 17 bits) and mdata_w (input, 20 bits): memory request.
REQ-008 SHALL have port mdata_r, output, 20 bits: read data.
REQ-009 SHALL have ports ld_valid (input, 1), ld_sel (input, 3), ld_addr (input, 12), ld_data (input, 32) and ld_ready (output, 1): preload port.
REQ-010 SHALL have port ld_start, input, 1 bit: end of preload, arms the job.
REQ-011 SHALL have ports wr_valid (output, 1), wr_addr (output, 17) and wr_data (output, 20): h(t) result stream.
REQ-012 SHALL have ports done (output, 1, one-cycle pulse) and err (output, 4 bits, sticky).

Function
REQ-013 SHALL provide these banks, all 20-bit signed:
- W_ih: msel 000, 2048 entries, address maddr[10:0].
- b_ih: msel 001, 64 entries, address maddr[5:0].
- W_hh: msel 010, 4096 entries, address maddr[11:0].
- b_hh: msel 011, 64 entries, address maddr[5:0].
- T: msel 100, one 11-bit register.
REQ-014 SHALL drive mdata_r combinationally from msel/maddr in the same cycle, with zero latency.
- msel 100 SHALL return {9'b0,T}.
- msel 101, 110 and 111 SHALL return 0.
REQ-015 SHALL ignore mce for reads; when mce=1 and msel=101, SHALL register wr_valid=1, wr_addr=maddr and wr_data=mdata_w on the next cycle.
REQ-016 SHALL accept a preload beat on ld_valid&&ld_ready.
- ld_sel 000-100 SHALL write ld_data[19:0] into the bank or T selected by ld_sel.
- ld_sel 110 SHALL push the full ld_data[31:0] into the input FIFO.
REQ-017 SHALL use a 4-entry input FIFO.
- idata SHALL equal the head word, or 0 when the FIFO is empty.
- i_en SHALL pop the head in the same cycle.
- A simultaneous push and pop SHALL keep the count unchanged.
REQ-018 SHALL implement FSM IDLE, ARM, RUN, DONE with these transitions:
- IDLE->ARM on ld_start.
- ARM->RUN on busy=1.
- RUN->DONE when the write count reaches T*64.
- DONE->IDLE after one cycle.
REQ-019 SHALL set ld_ready per state:
- IDLE: 1 for all ld_sel.
- ARM/RUN: 1 only while ld_sel=110 and the FIFO is not full.
- DONE: 0.
REQ-020 SHALL drive ready=1 only in ARM while the FIFO is non-empty.
REQ-021 SHALL assert done in DONE only.
REQ-022 SHALL clear the 17-bit write counter on entry to ARM.
REQ-023 SHALL set err bits as follows:
- err[0]: i_en on an empty FIFO.
- err[1]: busy fell in RUN before T*64 writes.
- err[2]: msel 101 write while not in RUN.
- err[3]: write count exceeds T*64.
REQ-024 SHALL clamp T=0 to a job of zero writes: RUN->DONE on the first cycle of RUN.

Reset
REQ-025 SHALL on reset=0 force:
- state IDLE;
- FIFO empty, write counter 0, T=0;
- ready, wr_valid, done and err all 0;
- wr_addr and wr_data 0.
REQ-026 SHALL leave bank contents unreset.
REQ-027 SHALL on reset mid-RUN drop all pending output immediately and, on release, start from IDLE.

Configuration
REQ-028 SHALL with macro RNN_RESP_CHECK_EN defined implement err per REQ-023.
REQ-029 SHALL without RNN_RESP_CHECK_EN tie err to 4'b0000 and remove all checker logic; all other behaviour SHALL be identical.

Structure
REQ-030 SHALL take from shared package rnn_pkg:
- msel encodings, localparams MSEL_WIH, MSEL_BIH, MSEL_WHH, MSEL_BHH, MSEL_T and MSEL_H;
- ld_sel 110 as LD_X;
- bank depths, data width 20 and H=64;
- the state enum.
REQ-031 SHALL place the input FIFO in one sub-module, rnn_in_fifo (depth 4, width 32).

Verification
REQ-032 Bank readback: preload W_hh[0x123]=0x0ABCD, then drive msel=010, maddr=0x00123 -> mdata_r=0x0ABCD in the same cycle.
REQ-033 Start handshake: preload T=2 and one FIFO word 0xDEADBEEF, then pulse ld_start -> ready=1 next cycle; busy=1 -> ready=0 and state RUN; i_en pulse -> idata=0xDEADBEEF in that cycle, FIFO empty after.
REQ-034 Result stream: T=2 in RUN, 128 writes with msel=101, maddr=n, mdata_w=n -> 128 wr_valid beats with matching addr/data, then done pulses once and state IDLE.
REQ-035 Underflow (macro on): i_en with the FIFO empty -> idata=0 and err[0]=1 sticky.
REQ-036 Underflow (macro off): the same stimulus -> err stays 0.
REQ-037 Reset mid-run: reset=0 after 40 writes -> wr_valid=0 and ready=0 asynchronously; after release, state is IDLE and the counter is 0.
REQ-038 FIFO edge: 4 pushes -> ld_ready=0 for ld_sel=110; a simultaneous push and pop when full is refused, and the count goes to 3.
